uart_rcv_fifo: RTL and testbench
================================

// Module: uart_rcv_fifo
// PURPOSE
//  Parametrised UART receiver for the Segway serial link: DATA_BITS data bits, LSB first, 1 stop bit.
//  Fixed divisor BAUD_DIV clocks per bit (2604 = 19200 baud at 50MHz).
//  Adds false-start rejection, framing/overrun detection and a show-ahead RX FIFO so the consumer
//  can pop words at its own pace.
//  Sits between the async RX pin and the command-processing logic.
// PARAMETERS
//  DATA_BITS   8     data bits per frame, legal 5..9
//  BAUD_DIV    2604  clk cycles per bit, >=8
//  FIFO_DEPTH  4     RX FIFO entries, power of 2, >=2
//  PARITY_ODD  0     1=odd, 0=even parity; used only when UART_RCV_PARITY_EN is defined
// PORTS
//  clk       in   1                      system clock
//  rst       in   1                      asynchronous, active-high reset
//  RX        in   1                      async serial input, idles high
//  rd_en     in   1                      pop FIFO head; ignored when empty
//  clr_err   in   1                      clear all sticky error flags
//  rdy       out  1                      FIFO not empty
//  rx_data   out  DATA_BITS              FIFO head word (show-ahead)
//  fifo_cnt  out  $clog2(FIFO_DEPTH+1)   FIFO occupancy
//  frm_err   out  1                      sticky: stop bit sampled 0
//  ovr_err   out  1                      sticky: word dropped, FIFO full
//  par_err   out  1                      sticky: parity mismatch; tied 0 when the macro is undefined
// BEHAVIOUR
//  Reset values:
//   - rdy=0, fifo_cnt=0, rx_data=0, all error flags=0.
//   - FIFO empty, state=IDLE, RX sync flops=1.
//  Reset mid-frame aborts the frame; the partial word is lost.
//  RX is double-flopped -> rx_s. Start is detected on a falling edge of rx_s (prev 1, now 0).
//   - A line held low (break, or a bad stop) never retriggers a start.
//  baud_cnt counts down; the bit is sampled when it reaches 0.
//   - Loaded with BAUD_DIV/2-1 on start detect, and with BAUD_DIV-1 after every sample.
//  States:
//   - IDLE   : on falling edge of rx_s -> START.
//   - START  : at the mid-bit sample:
//              rx_s=1 -> IDLE (glitch; no push, no flag).
//              rx_s=0 -> DATA, bit_cnt=0.
//   - DATA   : shift rx_s into the MSB of the shift register (LSB-first frame).
//              After DATA_BITS samples -> PARITY if the macro is defined, else -> STOP.
//   - PARITY : compare the sample with the computed parity; latch the mismatch -> STOP.
//   - STOP   : sample -> IDLE.
//              rx_s=1 with no parity mismatch -> push word.
//              rx_s=0 -> set frm_err, discard word.
//              Parity mismatch (stop ok) -> set par_err, discard word.
//  FIFO:
//   - Push occurs on the stop-sample edge; rdy/rx_data valid the next cycle.
//   - Push while full (no simultaneous pop) -> word dropped, ovr_err=1, FIFO contents unchanged.
//   - Push and pop in the same cycle: both take effect, fifo_cnt unchanged. Legal when full.
//   - Pop while empty: no effect. Pointers wrap modulo FIFO_DEPTH.
//   - rx_data is don't-care while rdy=0.
//  Error flags: set has priority over clr_err in the same cycle.
//  Back-to-back frames: a start edge right after the stop sample is accepted; no idle bit required.
// CONFIGURATION
//  UART_RCV_PARITY_EN defined:
//   - Frame carries one parity bit between the data bits and the stop bit.
//   - PARITY state is active; par_err is live.
//   - Even parity: XOR of data and parity bits = 0 (PARITY_ODD=0).
//  UART_RCV_PARITY_EN undefined:
//   - No parity bit; PARITY state and its logic are not built; par_err = 0 constant.
// TESTING  (BAUD_DIV=16, FIFO_DEPTH=4 unless stated)
//  1. Frame 0xA5, stop=1 -> rdy=1 one cycle after the stop sample, rx_data=0xA5, fifo_cnt=1.
//     Pulse rd_en -> rdy=0, fifo_cnt=0.
//  2. RX low for 4 clks then high -> START rejects it.
//     No push, no error; a following 0x3C is received correctly.
//  3. Frame 0x3C with stop=0 -> frm_err=1, fifo_cnt=0, no retrigger while RX stays low.
//     clr_err -> frm_err=0.
//  4. Five frames 0x01..0x05 with no pop -> fifo_cnt=4, ovr_err=1.
//     Pops return 0x01,0x02,0x03,0x04. Repeat with rd_en coincident with the 5th push: no overrun.
//  5. UART_RCV_PARITY_EN, PARITY_ODD=0:
//     0x01 with parity bit 0 -> par_err=1, no push.
//     0x01 with parity bit 1 -> push 0x01.
//  6. rst pulsed mid-data of 0x5A -> all outputs reset values.
//     Next 0xC3 received correctly; repeat with DATA_BITS=7, 0x55.

Source files
------------

// File: rtl/uart_rcv_fifo_if.sv
// Bundle of the serial line, FIFO pop/clear controls and receiver status outputs.
// The master side drives RX and the consumer controls; the slave side is the receiver.
interface uart_rcv_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                 RX;
    logic                 rd_en;
    logic                 clr_err;
    logic                 rdy;
    logic [DATA_BITS-1:0] rx_data;
    logic [CNT_W-1:0]     fifo_cnt;
    logic                 frm_err;
    logic                 ovr_err;
    logic                 par_err;

    modport master (
        output RX, rd_en, clr_err,
        input  rdy, rx_data, fifo_cnt, frm_err, ovr_err, par_err
    );

    modport slave (
        input  RX, rd_en, clr_err,
        output rdy, rx_data, fifo_cnt, frm_err, ovr_err, par_err
    );
endinterface

// File: rtl/uart_rcv_fifo.sv
// UART receiver (LSB first, one stop bit) with false-start rejection, sticky
// framing/overrun/parity flags and a show-ahead RX FIFO.
// Optional parity bit: define UART_RCV_PARITY_EN to build the PARITY state and a live par_err.
module uart_rcv_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 2604,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    uart_rcv_fifo_if.slave   bus
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam int CW = $clog2(DATA_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam logic [BW-1:0] HALF_LOAD = BW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0] FULL_LOAD = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
    localparam logic [NW-1:0] DEPTH     = NW'(FIFO_DEPTH);

    // Reject illegal configurations at elaboration time.
    if (DATA_BITS < 5 || DATA_BITS > 9 || BAUD_DIV < 8 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_rcv_fifo: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_RCV_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t               r_state, w_next;
    logic                 r_rx_meta, r_rx_s, r_rx_d;
    logic [BW-1:0]        r_baud_cnt;
    logic [CW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 w_fall, w_tick, w_push, w_frm_set;
    logic                 r_frm_err, r_ovr_err;
`ifdef UART_RCV_PARITY_EN
    logic                 r_par_bad, r_par_err, w_par_set;
`endif

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [NW-1:0]        r_cnt;
    logic                 w_empty, w_full, w_pop, w_wr, w_ovr_set;

    assign w_fall = r_rx_d & ~r_rx_s;
    assign w_tick = (r_baud_cnt == '0);

    // Double-flop the async RX pin and keep one more stage for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_d    <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_rx_meta <= bus.RX;
            r_rx_s    <= r_rx_meta;
            r_rx_d    <= r_rx_s;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode and stop-bit verdict (push / framing / parity).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_next    = r_state;
        w_push    = 1'b0;
        w_frm_set = 1'b0;
`ifdef UART_RCV_PARITY_EN
        w_par_set = 1'b0;
`endif
        unique case (r_state)
            S_IDLE:  if (w_fall) w_next = S_START;
            S_START: if (w_tick) w_next = r_rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (w_tick && (r_bit_cnt == LAST_BIT)) begin
`ifdef UART_RCV_PARITY_EN
                w_next = S_PARITY;
`else
                w_next = S_STOP;
`endif
            end
`ifdef UART_RCV_PARITY_EN
            S_PARITY: if (w_tick) w_next = S_STOP;
`endif
            S_STOP:  if (w_tick) begin
                w_next = S_IDLE;
                if (!r_rx_s)         w_frm_set = 1'b1;
`ifdef UART_RCV_PARITY_EN
                else if (r_par_bad)  w_par_set = 1'b1;
`endif
                else                 w_push    = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Baud down-counter, bit counter and LSB-first shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_fall) r_baud_cnt <= HALF_LOAD;
        end else if (!w_tick) begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
        end else begin
            r_baud_cnt <= FULL_LOAD;
            if (r_state == S_START) r_bit_cnt <= '0;
            if (r_state == S_DATA) begin
                r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

`ifdef UART_RCV_PARITY_EN
    // Latch whether the received parity bit disagrees with the data word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 r_par_bad <= 1'b0;
        else if (r_state == S_PARITY && w_tick)  r_par_bad <= r_rx_s ^ (^r_shift) ^ 1'(PARITY_ODD);
    end

    // Sticky parity flag; a new error wins over clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_par_err <= 1'b0;
        else if (w_par_set)   r_par_err <= 1'b1;
        else if (bus.clr_err) r_par_err <= 1'b0;
    end
    assign bus.par_err = r_par_err;
`else
    assign bus.par_err = 1'b0;
`endif

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == DEPTH);
    assign w_pop     = bus.rd_en & ~w_empty;
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_ovr_set = w_push & w_full & ~w_pop;

    // FIFO storage write port.
    // NOTE: the storage array is not reset; only the pointers and count are, which is enough to mark it empty.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_shift;
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_wr && w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

    // Sticky framing and overrun flags; a new error wins over clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frm_err <= 1'b0;
            r_ovr_err <= 1'b0;
        end else begin
            if (w_frm_set)        r_frm_err <= 1'b1;
            else if (bus.clr_err) r_frm_err <= 1'b0;
            if (w_ovr_set)        r_ovr_err <= 1'b1;
            else if (bus.clr_err) r_ovr_err <= 1'b0;
        end
    end

    assign bus.rdy      = ~w_empty;
    assign bus.rx_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.fifo_cnt = r_cnt;
    assign bus.frm_err  = r_frm_err;
    assign bus.ovr_err  = r_ovr_err;
endmodule

// File: tb/tb_uart_rcv_fifo.sv
// Directed bench for uart_rcv_fifo: an 8-bit and a 7-bit receiver, BAUD_DIV=16, FIFO_DEPTH=4.
// Builds with or without UART_RCV_PARITY_EN; parity cases run only when it is defined.
module tb_uart_rcv_fifo;
    localparam int BAUD = 16;
`ifdef UART_RCV_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic pre_rdy, post_rdy;

    uart_rcv_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if8 ();
    uart_rcv_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if7 ();

    uart_rcv_fifo #(.DATA_BITS(8), .BAUD_DIV(BAUD), .FIFO_DEPTH(4), .PARITY_ODD(0)) dut8 (
        .clk(clk), .rst(rst), .bus(if8)
    );
    uart_rcv_fifo #(.DATA_BITS(7), .BAUD_DIV(BAUD), .FIFO_DEPTH(4), .PARITY_ODD(0)) dut7 (
        .clk(clk), .rst(rst), .bus(if7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) if7.RX = v;
        else     if8.RX = v;
    endtask

    task automatic pop(input bit sel);
        if (sel) if7.rd_en = 1'b1;
        else     if8.rd_en = 1'b1;
        @(negedge clk);
        if7.rd_en = 1'b0;
        if8.rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        if8.clr_err = 1'b1;
        @(negedge clk);
        if8.clr_err = 1'b0;
    endtask

    // Sends start, data (LSB first), optional parity, stop. Starts on a negedge.
    // rdy is recorded one clock before and one clock after the stop-sample edge;
    // pop_at_stop raises rd_en exactly over that edge.
    task automatic send_frame(input bit sel, input logic [8:0] data, input logic stop,
                              input bit flip_par, input bit pop_at_stop);
        int         nd;
        int         nb;
        logic       par;
        logic [11:0] bits;
        nd   = sel ? 7 : 8;
        par  = flip_par;
        bits = '0;
        for (int i = 0; i < nd; i++) begin
            par         = par ^ data[i];
            bits[1 + i] = data[i];
        end
        nb = 1 + nd;
        if (PAR_EN) begin
            bits[nb] = par;
            nb++;
        end
        bits[nb] = stop;
        nb++;
        for (int i = 0; i < nb - 1; i++) begin
            set_rx(sel, bits[i]);
            repeat (BAUD) @(negedge clk);
        end
        set_rx(sel, stop);
        repeat (10) @(negedge clk);
        pre_rdy = sel ? if7.rdy : if8.rdy;
        if (pop_at_stop) begin
            if (sel) if7.rd_en = 1'b1;
            else     if8.rd_en = 1'b1;
        end
        @(negedge clk);
        if7.rd_en = 1'b0;
        if8.rd_en = 1'b0;
        post_rdy = sel ? if7.rdy : if8.rdy;
        repeat (5) @(negedge clk);
    endtask

    // Sends only the first nb bits (start plus some data) of a frame.
    task automatic send_partial(input bit sel, input logic [8:0] data, input int nb);
        logic [9:0] bits;
        bits = {data, 1'b0};
        for (int i = 0; i < nb; i++) begin
            set_rx(sel, bits[i]);
            repeat (BAUD) @(negedge clk);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        if8.RX = 1'b1; if8.rd_en = 1'b0; if8.clr_err = 1'b0;
        if7.RX = 1'b1; if7.rd_en = 1'b0; if7.clr_err = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_rdy",     32'(if8.rdy),      32'h0);
        check("rst_cnt",     32'(if8.fifo_cnt), 32'h0);
        check("rst_data",    32'(if8.rx_data),  32'h0);
        check("rst_frm",     32'(if8.frm_err),  32'h0);
        check("rst_ovr",     32'(if8.ovr_err),  32'h0);
        check("rst_par",     32'(if8.par_err),  32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: 0xA5, rdy rises one clock after the stop sample, then pop
        send_frame(1'b0, 9'h0A5, 1'b1, 1'b0, 1'b0);
        check("t1_rdy_before", 32'(pre_rdy),      32'h0);
        check("t1_rdy_after",  32'(post_rdy),     32'h1);
        check("t1_data",       32'(if8.rx_data),  32'hA5);
        check("t1_cnt",        32'(if8.fifo_cnt), 32'h1);
        pop(1'b0);
        check("t1_pop_rdy",    32'(if8.rdy),      32'h0);
        check("t1_pop_cnt",    32'(if8.fifo_cnt), 32'h0);

        // 2: 4-clock low glitch is rejected, then 0x3C arrives intact
        set_rx(1'b0, 1'b0);
        repeat (4) @(negedge clk);
        set_rx(1'b0, 1'b1);
        repeat (40) @(negedge clk);
        check("t2_glitch_cnt", 32'(if8.fifo_cnt), 32'h0);
        check("t2_glitch_frm", 32'(if8.frm_err),  32'h0);
        send_frame(1'b0, 9'h03C, 1'b1, 1'b0, 1'b0);
        check("t2_data",       32'(if8.rx_data),  32'h3C);
        check("t2_cnt",        32'(if8.fifo_cnt), 32'h1);
        pop(1'b0);

        // 3: bad stop bit, line held low, then clr_err
        send_frame(1'b0, 9'h03C, 1'b0, 1'b0, 1'b0);
        check("t3_frm",        32'(if8.frm_err),  32'h1);
        check("t3_cnt",        32'(if8.fifo_cnt), 32'h0);
        pulse_clr();
        check("t3_clr",        32'(if8.frm_err),  32'h0);
        repeat (220) @(negedge clk);
        check("t3_no_retrig_frm", 32'(if8.frm_err),  32'h0);
        check("t3_no_retrig_cnt", 32'(if8.fifo_cnt), 32'h0);
        set_rx(1'b0, 1'b1);
        repeat (32) @(negedge clk);
        send_frame(1'b0, 9'h011, 1'b1, 1'b0, 1'b0);
        check("t3_next_data",  32'(if8.rx_data),  32'h11);
        pop(1'b0);

        // 4: overrun on the fifth unpopped word
        for (int v = 1; v <= 5; v++) send_frame(1'b0, 9'(v), 1'b1, 1'b0, 1'b0);
        check("t4_cnt_full",   32'(if8.fifo_cnt), 32'h4);
        check("t4_ovr",        32'(if8.ovr_err),  32'h1);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("t4_pop%0d", k), 32'(if8.rx_data), 32'(k));
            pop(1'b0);
        end
        check("t4_cnt_empty",  32'(if8.fifo_cnt), 32'h0);
        pulse_clr();
        check("t4_ovr_clr",    32'(if8.ovr_err),  32'h0);

        // 4b: pop coincident with the push into a full FIFO
        for (int v = 1; v <= 4; v++) send_frame(1'b0, 9'(v), 1'b1, 1'b0, 1'b0);
        send_frame(1'b0, 9'h005, 1'b1, 1'b0, 1'b1);
        check("t4b_ovr",       32'(if8.ovr_err),  32'h0);
        check("t4b_cnt",       32'(if8.fifo_cnt), 32'h4);
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("t4b_pop%0d", k), 32'(if8.rx_data), 32'(k));
            pop(1'b0);
        end
        check("t4b_cnt_empty", 32'(if8.fifo_cnt), 32'h0);

`ifdef UART_RCV_PARITY_EN
        // 5: even parity, 0x01 with parity 0 is rejected, with parity 1 accepted
        send_frame(1'b0, 9'h001, 1'b1, 1'b1, 1'b0);
        check("t5_par_err",    32'(if8.par_err),  32'h1);
        check("t5_par_cnt",    32'(if8.fifo_cnt), 32'h0);
        pulse_clr();
        check("t5_par_clr",    32'(if8.par_err),  32'h0);
        send_frame(1'b0, 9'h001, 1'b1, 1'b0, 1'b0);
        check("t5_ok_err",     32'(if8.par_err),  32'h0);
        check("t5_ok_data",    32'(if8.rx_data),  32'h01);
        check("t5_ok_cnt",     32'(if8.fifo_cnt), 32'h1);
        pop(1'b0);
`endif

        // 6: reset mid-frame with a word queued and frm_err set
        send_frame(1'b0, 9'h077, 1'b1, 1'b0, 1'b0);
        send_frame(1'b0, 9'h012, 1'b0, 1'b0, 1'b0);
        set_rx(1'b0, 1'b1);
        repeat (32) @(negedge clk);
        check("t6_pre_cnt",    32'(if8.fifo_cnt), 32'h1);
        check("t6_pre_frm",    32'(if8.frm_err),  32'h1);
        send_partial(1'b0, 9'h05A, 5);
        rst = 1'b1;
        set_rx(1'b0, 1'b1);
        @(negedge clk);
        check("t6_rdy",        32'(if8.rdy),      32'h0);
        check("t6_cnt",        32'(if8.fifo_cnt), 32'h0);
        check("t6_data",       32'(if8.rx_data),  32'h0);
        check("t6_frm",        32'(if8.frm_err),  32'h0);
        check("t6_ovr",        32'(if8.ovr_err),  32'h0);
        rst = 1'b0;
        repeat (32) @(negedge clk);
        send_frame(1'b0, 9'h0C3, 1'b1, 1'b0, 1'b0);
        check("t6_c3_data",    32'(if8.rx_data),  32'hC3);
        check("t6_c3_cnt",     32'(if8.fifo_cnt), 32'h1);
        pop(1'b0);

        // 6b: same on the 7-bit receiver
        send_partial(1'b1, 9'h02A, 4);
        rst = 1'b1;
        set_rx(1'b1, 1'b1);
        @(negedge clk);
        check("t6b_rdy",       32'(if7.rdy),      32'h0);
        check("t6b_cnt",       32'(if7.fifo_cnt), 32'h0);
        rst = 1'b0;
        repeat (32) @(negedge clk);
        send_frame(1'b1, 9'h055, 1'b1, 1'b0, 1'b0);
        check("t6b_rdy_after", 32'(post_rdy),     32'h1);
        check("t6b_data",      32'(if7.rx_data),  32'h55);
        check("t6b_cnt",       32'(if7.fifo_cnt), 32'h1);
        check("t6b_frm",       32'(if7.frm_err),  32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
